// File: rtl/cnn_pkg.sv
// Shared CNN datapath types, widths and the saturating narrow helper.
// Latency: n/a (package, no logic state).
// Backpressure: n/a.
package cnn_pkg;

    localparam int CH_MAX     = 10;
    localparam int ACC_W      = 32;
    localparam int DATA_W     = 16;
    localparam int BIAS_SHIFT = 8;
    localparam int CH_W       = 4;
    localparam int ADDR_W     = 16;

    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic signed [DATA_W-1:0] act_t;
    typedef logic signed [ACC_W:0]    sum_t;

    // Saturate a widened sum to the activation range. The value fits when every
    // bit above the activation sign bit matches the sign of the sum.
    function automatic act_t sat16(input sum_t v);
        logic fits;
        act_t res;
        fits = (v[ACC_W:DATA_W-1] == {(ACC_W-DATA_W+2){v[ACC_W]}});
        if (fits) begin
            res = v[DATA_W-1:0];
        end else if (v[ACC_W]) begin
            res = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            res = {1'b0, {(DATA_W-1){1'b1}}};
        end
        return res;
    endfunction

endpackage

// File: rtl/sat_relu.sv
// Saturates the S1 sum to the activation range, then optionally clamps negatives to 0.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller's register enable decides when the result is used.
module sat_relu
    import cnn_pkg::*;
(
    input  logic [ACC_W:0]    sum,
    input  logic              relu_en,
    output logic [DATA_W-1:0] act
);

    act_t sat;

    // Narrow first, then ReLU, so a large negative sum still becomes exactly 0.
    always_comb begin
        sat = sat16(sum_t'(sum));
        act = sat;
        if (relu_en && sat[DATA_W-1]) begin
            act = '0;
        end
    end

endmodule

// File: rtl/bias_relu_stage.sv
// Bias add + requantize + saturate/ReLU on a channel-interleaved accumulator stream.
// Latency: 2 cycles accept-to-out_valid, 1 beat/cycle throughput.
// Backpressure: one global enable; a stalled output freezes both stages and drops in_ready.
module bias_relu_stage #(
    parameter int CH_MAX = cnn_pkg::CH_MAX,
    parameter int ACC_W  = cnn_pkg::ACC_W,
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int SHIFT  = cnn_pkg::BIAS_SHIFT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        cfg_ch_num,
    input  logic              relu_en,
    input  logic              layer_start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ACC_W-1:0]  in_acc,
    input  logic              in_last,
    output logic              read_bias_signal,
    output logic [15:0]       read_bias_addr,
    input  logic [15:0]       read_bias_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        out_ch,
    output logic              out_last,
    output logic              busy
);

    import cnn_pkg::*;

    logic              en;
    logic              accept;
    logic [CH_W-1:0]   ch_cnt;
    logic [CH_W-1:0]   cur_ch;
    logic [CH_W-1:0]   eff_n;
    logic              ch_wrap;

    logic signed [ACC_W-1:0] acc_sh;
    logic [ACC_W:0]          sum_in;

    logic              s1_vld;
    logic [ACC_W:0]    s1_sum;
    logic [CH_W-1:0]   s1_ch;
    logic              s1_last;
    logic              s1_relu;

    logic              s2_vld;
    logic [DATA_W-1:0] s2_dat;
    logic [CH_W-1:0]   s2_ch;
    logic              s2_last;

    logic [DATA_W-1:0] sat_act;

    // Whole pipeline advances together whenever the output slot is free or draining.
    assign en     = !s2_vld || out_ready;
    assign accept = in_valid && en;

    // Effective channel count: out-of-range programming falls back to the full bias table.
    always_comb begin
        eff_n = cfg_ch_num;
        if (cfg_ch_num == '0 || cfg_ch_num > CH_W'(CH_MAX)) begin
            eff_n = CH_W'(CH_MAX);
        end
    end

    // A layer_start beat is treated as channel 0 even before the counter clears.
    always_comb begin
        cur_ch  = layer_start ? '0 : ch_cnt;
        ch_wrap = (cur_ch == eff_n - 1'b1) || in_last;
    end

    // Output channel counter, advanced per accepted beat and wrapped at the layer width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_cnt <= '0;
        end else if (accept) begin
            ch_cnt <= ch_wrap ? '0 : cur_ch + 1'b1;
        end else if (layer_start) begin
            ch_cnt <= '0;
        end
    end

    assign read_bias_signal = accept;
    assign read_bias_addr   = {{(16-CH_W){1'b0}}, cur_ch};

    // Requantize then add bias in one extra bit so the sum itself can never wrap.
    always_comb begin
        acc_sh = $signed(in_acc) >>> SHIFT;
        sum_in = {acc_sh[ACC_W-1], acc_sh}
               + {{(ACC_W+1-DATA_W){read_bias_data[DATA_W-1]}}, read_bias_data};
    end

    // S1: capture the sum along with the beat's channel, last flag and ReLU mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_sum  <= '0;
            s1_ch   <= '0;
            s1_last <= 1'b0;
            s1_relu <= 1'b0;
        end else if (en) begin
            s1_vld  <= accept;
            s1_sum  <= sum_in;
            s1_ch   <= cur_ch;
            s1_last <= in_last;
            s1_relu <= relu_en;
        end
    end

    sat_relu u_sat_relu (
        .sum     (s1_sum),
        .relu_en (s1_relu),
        .act     (sat_act)
    );

    // S2: registered activation; holds stable while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld  <= 1'b0;
            s2_dat  <= '0;
            s2_ch   <= '0;
            s2_last <= 1'b0;
        end else if (en) begin
            s2_vld  <= s1_vld;
            s2_dat  <= sat_act;
            s2_ch   <= s1_ch;
            s2_last <= s1_last;
        end
    end

    assign in_ready  = en;
    assign out_valid = s2_vld;
    assign out_data  = s2_dat;
    assign out_ch    = s2_ch;
    assign out_last  = s2_last;
    assign busy      = s1_vld || s2_vld;

endmodule
